window_stream_buffer: RTL
=========================

Name: window_stream_buffer

Overview:
- Streaming sliding-window generator for the CNN convolution datapath: accepts one raster-order pixel per handshake and emits KERNEL_SIZE x KERNEL_SIZE windows to the MAC array.
- Next generation of the image line-buffer block. Adds configurable stride, suppression of windows that straddle a row edge, ready/valid backpressure on both sides, synchronous reset and a frame-done pulse.

Parameters:
- KERNEL_SIZE, 3, window edge length; must satisfy 2 <= KERNEL_SIZE <= min(ROW_SIZE, COLUMN_SIZE).
- DATA_SIZE, 16, bits per pixel (fixed-point, opaque to this block).
- ROW_SIZE, 5, pixels per image row (image width).
- COLUMN_SIZE, 5, rows per frame (image height).
- STRIDE, 1, window step in both directions; must be >= 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_in_valid  in  1  data_in holds a valid pixel.
- data_in_ready  out  1  block can accept a pixel this cycle.
- data_in  in  DATA_SIZE  pixel, raster order, row-major.
- kernel_out  out  KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE  window; element e = i*KERNEL_SIZE+j (i = row, 0 = top/oldest; j = column, 0 = leftmost) at bits [e*DATA_SIZE +: DATA_SIZE].
- out_valid  out  1  kernel_out holds a valid window.
- out_ready  in  1  consumer takes the window this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Accept: a pixel is accepted when data_in_valid && data_in_ready.
  - data_in_ready = !out_valid || out_ready (combinational).
  - No internal state changes on cycles without an accept, except the clearing of out_valid and frame_done.
- Position tracking: col (0..ROW_SIZE-1) and row (0..COLUMN_SIZE-1) counters give the position of the next pixel.
  - On accept, col increments. At col == ROW_SIZE-1 it wraps to 0 and row increments.
  - At row == COLUMN_SIZE-1 and col == ROW_SIZE-1 both wrap to 0.
- Storage: KERNEL_SIZE-1 line buffers of depth ROW_SIZE plus a KERNEL_SIZE x KERNEL_SIZE window shift register. All shift only on accept.
- Window emit condition, evaluated on accepting the pixel at (row r, col c), all terms required:
  - r >= KERNEL_SIZE-1
  - c >= KERNEL_SIZE-1
  - (r-KERNEL_SIZE+1) % STRIDE == 0
  - (c-KERNEL_SIZE+1) % STRIDE == 0
- When the condition holds, the next cycle has out_valid=1 and kernel_out = the window whose top-left pixel is (r-KERNEL_SIZE+1, c-KERNEL_SIZE+1). Latency is one cycle from accept.
- Window count per frame is ((ROW_SIZE-KERNEL_SIZE)/STRIDE+1) * ((COLUMN_SIZE-KERNEL_SIZE)/STRIDE+1), integer division. A window never spans a row boundary.
- Output register update:
  - An accept that meets the emit condition loads kernel_out and sets out_valid.
  - Otherwise, out_valid && out_ready clears out_valid.
  - kernel_out holds its value while out_valid && !out_ready.
- Backpressure stalls the input only. No pixel or window is dropped or duplicated.
- frame_done: registered pulse, high for exactly one cycle in the cycle after the accept of pixel (COLUMN_SIZE-1, ROW_SIZE-1). It is independent of out_ready.
- Frame boundary: counters wrap and the next frame starts immediately, back-to-back. Stale line-buffer data from the previous frame never reaches an emitted window, because rows < KERNEL_SIZE-1 emit nothing.
- Reset (synchronous, at any point including mid-frame):
  - row=0, col=0, out_valid=0, frame_done=0, kernel_out=0.
  - The next accepted pixel is treated as (0,0).
  - Line-buffer and window contents need not be cleared.
- Counter widths are $clog2 of the range, minimum 1 bit. Stride phase is tracked with per-axis phase counters, not division.

Test Plan:
- K=3, R=C=5, S=1, pixels 0..24 streamed, out_ready=1 -> 9 windows. The first appears the cycle after pixel 12 is accepted, with elements 0,1,2,5,6,7,10,11,12. No window follows pixels 15 or 16. frame_done pulses once, after pixel 24.
- Same configuration with S=2 -> exactly 4 windows, following pixels 12, 14, 22 and 24. The window after pixel 24 contains 12,13,14,17,18,19,22,23,24.
- Backpressure: out_ready=0 while a window is pending -> data_in_ready=0 and kernel_out stable for 5 cycles. Releasing out_ready continues the stream without loss; the total is still 9 windows and the data matches the reference model.
- Random data_in_valid gaps (50% duty) with random out_ready -> window sequence identical to the gap-free run.
- Two frames back-to-back: frame 1 is 100..124, frame 2 is 200..224 -> the first window of frame 2 contains only 2xx values. frame_done pulses twice.
- Assert reset after pixel 8, then stream 0..24 -> out_valid=0 in the cycle after reset, then exactly 9 correct windows.

Source files
------------

// File: rtl/window_stream_buffer.sv
// Streaming KxK sliding-window generator: raster pixels in, stride-filtered windows out,
// with ready/valid on both sides and a one-cycle frame-done pulse.
module window_stream_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 16,
    parameter int ROW_SIZE    = 5,
    parameter int COLUMN_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         data_in_valid,
    output logic                                         data_in_ready,
    input  logic [DATA_SIZE-1:0]                         data_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] kernel_out,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         frame_done
);

    localparam int KW = KERNEL_SIZE * KERNEL_SIZE * DATA_SIZE;
    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(COLUMN_SIZE - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KERNEL_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [PW-1:0]        r_cph;
    logic [PW-1:0]        r_rph;
    logic [DATA_SIZE-1:0] r_lb  [KERNEL_SIZE-1][ROW_SIZE];
    logic [DATA_SIZE-1:0] r_win [KERNEL_SIZE][KERNEL_SIZE];
    logic [KW-1:0]        r_kernel;
    logic                 r_out_valid;
    logic                 r_frame_done;

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_col_last;
    logic                 w_row_last;
    logic [DATA_SIZE-1:0] w_tap      [KERNEL_SIZE];
    logic [DATA_SIZE-1:0] w_win_next [KERNEL_SIZE][KERNEL_SIZE];
    logic [KW-1:0]        w_win_flat;

    assign data_in_ready = !r_out_valid || out_ready;
    assign w_accept      = data_in_valid && data_in_ready;
    assign w_col_last    = (r_col == COL_LAST);
    assign w_row_last    = (r_row == ROW_LAST);
    // Phase counters are held at zero until the first full window position on each axis.
    assign w_emit        = w_accept && (r_row >= ROW_K) && (r_col >= COL_K) &&
                           (r_rph == '0) && (r_cph == '0);

    assign kernel_out = r_kernel;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

    // Tap b of the line-buffer chain is the pixel b+1 rows above the incoming one.
    always_comb begin
        w_tap[KERNEL_SIZE-1] = data_in;
        for (int unsigned b = 0; b < KERNEL_SIZE - 1; b++) begin
            w_tap[KERNEL_SIZE-2-b] = r_lb[b][ROW_SIZE-1];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            for (int unsigned j = 0; j < KERNEL_SIZE - 1; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
            w_win_next[i][KERNEL_SIZE-1] = w_tap[i];
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
                w_win_flat[(i*KERNEL_SIZE+j)*DATA_SIZE +: DATA_SIZE] = w_win_next[i][j];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_lb[0][0] <= data_in;
            for (int unsigned b = 1; b < KERNEL_SIZE - 1; b++) begin
                r_lb[b][0] <= r_lb[b-1][ROW_SIZE-1];
            end
            for (int unsigned b = 0; b < KERNEL_SIZE - 1; b++) begin
                for (int unsigned d = 1; d < ROW_SIZE; d++) begin
                    r_lb[b][d] <= r_lb[b][d-1];
                end
            end
            r_win <= w_win_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
            r_cph <= '0;
            r_rph <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_cph <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_rph <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                    if (r_row < ROW_K) r_rph <= '0;
                    else               r_rph <= (r_rph == PH_LAST) ? '0 : r_rph + PW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
                if (r_col < COL_K) r_cph <= '0;
                else               r_cph <= (r_cph == PH_LAST) ? '0 : r_cph + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_kernel     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_emit) begin
                r_kernel    <= w_win_flat;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
